ctrl_word_encoder: RTL and testbench

//  Encoder/issuer side of the 25-bit control-word interface consumed by the combinational control decoder.

---
 rtl/ctrl_word_pkg.sv | 56 +++++
 rtl/cmd_fifo.sv | 81 ++++++++
 rtl/ctrl_word_encoder.sv | 180 ++++++++++++++++++
 tb/tb_ctrl_word_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_word_pkg.sv
// Shared types, field layout and word-building helpers for the control-word encoder.
package ctrl_word_pkg;

    localparam int CW_W    = 25;
    localparam int OP_W    = 5;
    localparam int FLAGS_W = 12;
    localparam int IMM_W   = 16;
    localparam int TAG_W   = 4;

    localparam logic [OP_W-1:0] OP_EXT = 5'h1F;

    // Head word layout: op | flags | imm[7:0]
    localparam int HEAD_OP_LSB    = 20;
    localparam int HEAD_FLAGS_LSB = 8;
    localparam int HEAD_IMM_LSB   = 0;
    localparam int HEAD_IMM_W     = 8;

    // Extension word layout: OP_EXT | tag | imm[15:0].
    // A 25-bit word has no room for a pad bit between tag and immediate,
    // so the tag sits directly above the full immediate.
    localparam int EXT_OP_LSB  = 20;
    localparam int EXT_TAG_LSB = 16;
    localparam int EXT_IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        EXT  = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [FLAGS_W-1:0] flags;
        logic [IMM_W-1:0]   imm;
        logic [TAG_W-1:0]   tag;
    } cmd_t;

    localparam int CMD_W = OP_W + FLAGS_W + IMM_W + TAG_W;

    // First word of every command.
    function automatic logic [CW_W-1:0] head_word(input cmd_t c);
        return {c.op, c.flags, c.imm[HEAD_IMM_W-1:0]};
    endfunction

    // Second word, carrying the full immediate and the command tag.
    function automatic logic [CW_W-1:0] ext_word(input cmd_t c);
        return {OP_EXT, c.tag, c.imm};
    endfunction

    // A command needs a second word when its immediate does not fit the
    // head word, or when its opcode is forced to always carry one.
    function automatic logic need_ext(input cmd_t c, input logic [31:0] mask);
        return (c.imm[IMM_W-1:HEAD_IMM_W] != 8'h00) || mask[c.op];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with valid/ready on both sides.
// in_ready is registered from the next-cycle occupancy, so a full FIFO
// refuses a push even when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_ptr_nxt_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic             in_ready_r;
    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic             full_nxt_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign push_s    = in_valid & in_ready_r;
    assign pop_s     = out_ready & ~empty_s;
    assign in_ready  = in_ready_r;
    assign out_valid = ~empty_s;
    assign out_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Next pointer values and the full flag they imply.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        full_nxt_s = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                     (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    end

    // Pointer and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            in_ready_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            in_ready_r <= ~full_nxt_s;
        end
    end

    // Storage array, written on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/ctrl_word_encoder.sv
// Control-word encoder: buffers abstract commands and serialises each one
// into a head word and, when needed, an extension word on a registered
// valid/ready output port.
module ctrl_word_encoder
    import ctrl_word_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] EXT_OP_MASK = 32'h0000_3000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [FLAGS_W-1:0]  cmd_flags,
    input  logic [IMM_W-1:0]    cmd_imm,
    output logic                word_valid,
    input  logic                word_ready,
    output logic [CW_W-1:0]     word_data,
    output logic                word_last,
    output logic                cmd_err,
    output logic [TAG_W-1:0]    tag_cnt
);

    logic             legal_s;
    logic             fifo_in_valid_s;
    logic             fifo_in_ready_s;
    logic             accept_s;
    cmd_t             in_cmd_s;
    logic             fifo_out_valid_s;
    logic [CMD_W-1:0] fifo_out_data_s;
    cmd_t             fifo_head_s;
    logic             pop_s;

    logic [TAG_W-1:0] tag_cnt_r;
    logic             cmd_err_r;

    fsm_e             state_r;
    fsm_e             state_nxt_s;
    cmd_t             hold_r;
    cmd_t             hold_nxt_s;
    logic             word_valid_r;
    logic             word_valid_nxt_s;
    logic [CW_W-1:0]  word_data_r;
    logic [CW_W-1:0]  word_data_nxt_s;
    logic             word_last_r;
    logic             word_last_nxt_s;

    assign legal_s         = (cmd_op != OP_EXT);
    assign fifo_in_valid_s = cmd_valid & legal_s;
    assign accept_s        = cmd_valid & fifo_in_ready_s;
    assign in_cmd_s        = '{op: cmd_op, flags: cmd_flags, imm: cmd_imm,
                               tag: tag_cnt_r + 4'd1};
    assign fifo_head_s     = cmd_t'(fifo_out_data_s);

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fifo_in_valid_s),
        .in_ready  (fifo_in_ready_s),
        .in_data   (in_cmd_s),
        .out_valid (fifo_out_valid_s),
        .out_ready (pop_s),
        .out_data  (fifo_out_data_s)
    );

    // Tag counter advances on every accepted legal command; illegal ones pulse cmd_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_r <= 4'd0;
            cmd_err_r <= 1'b0;
        end else begin
            if (accept_s && legal_s) begin
                tag_cnt_r <= tag_cnt_r + 4'd1;
            end
            cmd_err_r <= accept_s & ~legal_s;
        end
    end

    // Next state and next output words; loading a new head pops the FIFO.
    always_comb begin
        state_nxt_s      = state_r;
        hold_nxt_s       = hold_r;
        word_valid_nxt_s = word_valid_r;
        word_data_nxt_s  = word_data_r;
        word_last_nxt_s  = word_last_r;
        pop_s            = 1'b0;
        case (state_r)
            IDLE: begin
                if (fifo_out_valid_s) begin
                    pop_s            = 1'b1;
                    hold_nxt_s       = fifo_head_s;
                    state_nxt_s      = HEAD;
                    word_valid_nxt_s = 1'b1;
                    word_data_nxt_s  = head_word(fifo_head_s);
                    word_last_nxt_s  = ~need_ext(fifo_head_s, EXT_OP_MASK);
                end else begin
                    state_nxt_s      = IDLE;
                end
            end
            HEAD: begin
                if (word_ready) begin
                    if (need_ext(hold_r, EXT_OP_MASK)) begin
                        state_nxt_s      = EXT;
                        word_valid_nxt_s = 1'b1;
                        word_data_nxt_s  = ext_word(hold_r);
                        word_last_nxt_s  = 1'b1;
                    end else if (fifo_out_valid_s) begin
                        pop_s            = 1'b1;
                        hold_nxt_s       = fifo_head_s;
                        state_nxt_s      = HEAD;
                        word_valid_nxt_s = 1'b1;
                        word_data_nxt_s  = head_word(fifo_head_s);
                        word_last_nxt_s  = ~need_ext(fifo_head_s, EXT_OP_MASK);
                    end else begin
                        state_nxt_s      = IDLE;
                        word_valid_nxt_s = 1'b0;
                        word_data_nxt_s  = '0;
                        word_last_nxt_s  = 1'b0;
                    end
                end else begin
                    state_nxt_s = HEAD;
                end
            end
            EXT: begin
                if (word_ready) begin
                    if (fifo_out_valid_s) begin
                        pop_s            = 1'b1;
                        hold_nxt_s       = fifo_head_s;
                        state_nxt_s      = HEAD;
                        word_valid_nxt_s = 1'b1;
                        word_data_nxt_s  = head_word(fifo_head_s);
                        word_last_nxt_s  = ~need_ext(fifo_head_s, EXT_OP_MASK);
                    end else begin
                        state_nxt_s      = IDLE;
                        word_valid_nxt_s = 1'b0;
                        word_data_nxt_s  = '0;
                        word_last_nxt_s  = 1'b0;
                    end
                end else begin
                    state_nxt_s = EXT;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                word_valid_nxt_s = 1'b0;
                word_data_nxt_s  = '0;
                word_last_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, holding register and registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            hold_r       <= '0;
            word_valid_r <= 1'b0;
            word_data_r  <= '0;
            word_last_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            hold_r       <= hold_nxt_s;
            word_valid_r <= word_valid_nxt_s;
            word_data_r  <= word_data_nxt_s;
            word_last_r  <= word_last_nxt_s;
        end
    end

    assign cmd_ready  = fifo_in_ready_s;
    assign word_valid = word_valid_r;
    assign word_data  = word_data_r;
    assign word_last  = word_last_r;
    assign cmd_err    = cmd_err_r;
    assign tag_cnt    = tag_cnt_r;

endmodule

// File: tb/tb_ctrl_word_encoder.sv
// Scoreboard bench for ctrl_word_encoder: the driver pushes expected words
// computed from the command rules; a monitor pops and compares on each
// output handshake and also checks stall stability and cmd_err pulses.
module tb_ctrl_word_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [4:0]  cmd_op = 5'd0;
    logic [11:0] cmd_flags = 12'd0;
    logic [15:0] cmd_imm = 16'd0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [24:0] word_data;
    logic        word_last;
    logic        cmd_err;
    logic [3:0]  tag_cnt;

    always #5 clk = ~clk;

    ctrl_word_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_flags  (cmd_flags),
        .cmd_imm    (cmd_imm),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .cmd_err    (cmd_err),
        .tag_cnt    (tag_cnt)
    );

    typedef struct {
        logic [24:0] data;
        bit          last;
    } word_t;

    word_t exp_q[$];
    int    err_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    tag_m = 0;
    bit    rand_ready = 1'b0;
    bit    mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_ready) word_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit needs_ext(input int op, input int imm);
        return (imm >= 256) || (((32'h0000_3000 >> op) & 1) != 0);
    endfunction

    // Reference model: what an accepted command must produce.
    task automatic model_accept(input int op, input int flags, input int imm);
        word_t w;
        if (op == 31) begin
            err_q.push_back(cyc + 1);
        end else begin
            tag_m = (tag_m + 1) % 16;
            w.data = 25'(op * (1 << 20) + flags * (1 << 8) + (imm % 256));
            w.last = !needs_ext(op, imm);
            exp_q.push_back(w);
            if (needs_ext(op, imm)) begin
                w.data = 25'(31 * (1 << 20) + tag_m * (1 << 16) + imm);
                w.last = 1'b1;
                exp_q.push_back(w);
            end
        end
    endtask

    // Offer a command for exactly one clock; report whether it was taken.
    task automatic try_send(input int op, input int flags, input int imm, output bit acc);
        logic [31:0] v;
        @(negedge clk);
        v = op;    cmd_op    = v[4:0];
        v = flags; cmd_flags = v[11:0];
        v = imm;   cmd_imm   = v[15:0];
        cmd_valid = 1'b1;
        acc = cmd_ready;
        if (acc) model_accept(op, flags, imm);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (acc) chk("tag_cnt", tag_cnt, tag_m);
    endtask

    task automatic send(input int op, input int flags, input int imm);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 64) begin
            try_send(op, flags, imm, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    // Monitor: scoreboard pop, stall stability and cmd_err pulse checks.
    initial begin : monitor
        word_t       w;
        bit          prev_hold = 1'b0;
        logic [24:0] prev_data = 25'd0;
        logic        prev_last = 1'b0;
        bit          exp_err;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || !mon_en) begin
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                chk("stall_valid", word_valid, 1);
                chk("stall_data", word_data, prev_data);
                chk("stall_last", word_last, prev_last);
            end
            while (err_q.size() != 0 && err_q[0] < cyc) void'(err_q.pop_front());
            exp_err = (err_q.size() != 0 && err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            chk("cmd_err", cmd_err, exp_err);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", word_data, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", word_data, w.data);
                    chk("word_last", word_last, w.last);
                end
            end
            prev_hold = word_valid && !word_ready;
            prev_data = word_data;
            prev_last = word_last;
        end
    end

    initial begin : stimulus
        bit acc;
        int cnt;
        int n;
        int op;
        int imm;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_word_last", word_last, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_tag_cnt", tag_cnt, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // 1: single-word command, first-word latency of one cycle
        word_ready = 1'b0;
        send(5'h03, 12'hA5A, 16'h0042);
        chk("latency_early", word_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_valid", word_valid, 1);
        chk("t1_data", word_data, 25'h03A5A42);
        chk("t1_last", word_last, 1);
        @(negedge clk);
        word_ready = 1'b1;
        drain();
        chk("t1_tag", tag_cnt, 1);

        // 2: wide immediate needs an extension word
        send(5'h04, 12'h000, 16'h1234);
        drain();

        // 3: opcode forced to extend
        send(5'h0C, 12'h3C3, 16'h0007);
        drain();

        // 4: illegal opcode is dropped, flagged, tag unchanged
        send(5'h1F, 12'h111, 16'h0001);
        drain();
        chk("t4_tag", tag_cnt, 3);

        // 5: backpressure fills holding register plus FIFO
        word_ready = 1'b0;
        send(5'h01, 12'h001, 16'h0010);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            try_send(i + 2, $urandom_range(0, 4095), $urandom_range(0, 255), acc);
            if (acc) cnt++;
        end
        chk("t5_accepted", cnt, 4);
        chk("t5_ready_low", cmd_ready, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        word_ready = 1'b1;
        drain();

        // Randomised traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op  = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 30);
            imm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 65535);
            send(op, $urandom_range(0, 4095), imm);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        rand_ready = 1'b0;

        // 6b: reset while the extension word is pending
        @(negedge clk);
        word_ready = 1'b0;
        send(5'h04, 12'h000, 16'h1234);
        n = 0;
        while (!word_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_head_seen", word_valid, 1);
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        #1;
        chk("t6_ext_valid", word_valid, 1);
        chk("t6_ext_last", word_last, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", word_valid, 0);
        chk("t6_rst_data", word_data, 0);
        chk("t6_rst_last", word_last, 0);
        chk("t6_rst_tag", tag_cnt, 0);
        chk("t6_rst_ready", cmd_ready, 0);
        exp_q.delete();
        err_q.delete();
        tag_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        word_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_no_ext", word_valid, 0);
        chk("t6_fifo_empty", cmd_ready, 1);

        // 6a: tag wraps 15 -> 0 and lands on 1 after 17 commands
        for (int i = 0; i < 17; i++) begin
            send(5'h02, i, i);
        end
        chk("t6_tag_wrap", tag_cnt, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
